uart_tx: RTL and testbench

- Serial transmitter that consumes the one-cycle baud pulse from pulse_generator (`pulse_out` → `tick`) and frames parallel bytes into an asynchronous serial stream.
- Sits between the CPU's MMIO UART register block (upstream, valid/ready) and the `tx` pin.
- Each bit period is bounded by consecutive ticks, so the baud rate is set entirely by the pulse_generator divisor.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future receiver.
// Holds the transmitter FSM encoding, the parity mode encoding and the
// line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    typedef enum {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_mode_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a payload over valid/ready and serialises it
// on tx as start bit, data bits (LSB first), optional parity and stop
// bits. Every bit period is bounded by consecutive tick pulses.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   tick      one-cycle baud pulse per bit period
//   data_in   payload, bit 0 sent first
//   valid_in  upstream offers data_in
//   ready_out transmitter accepts a payload this cycle (registered)
//   tx        serial line, idles high (registered)
//   busy      high whenever the FSM is not idle (registered)
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DataBits   = 8,
    parameter int unsigned ParityMode = 0,
    parameter int unsigned StopBits   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [DataBits-1:0] data_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic                tx,
    output logic                busy
);

    localparam int unsigned CntW = $clog2(DataBits);
    localparam logic [CntW-1:0] LastBit = CntW'(DataBits - 1);
    localparam logic LastStop = 1'(StopBits - 1);
    localparam bit HasParity = (ParityMode != 32'(PARITY_NONE));
    localparam bit OddParity = (ParityMode == 32'(PARITY_ODD));

    // Reject illegal configurations at elaboration.
    if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
        $error("uart_tx: DataBits must be 5..9");
    end
    if (ParityMode > 2) begin : g_bad_parity_mode
        $error("uart_tx: ParityMode must be 0..2");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
        $error("uart_tx: StopBits must be 1..2");
    end

    uart_tx_state_e      state_q, state_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                stop_q, stop_d;
    logic                parity_q, parity_d;
    logic                tx_d;

    // Next-state, datapath and line-level decode.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        stop_d   = stop_q;
        parity_d = parity_q;
        tx_d     = UART_IDLE_LEVEL;

        unique case (state_q)
            IDLE: begin
                if (valid_in && ready_out) begin
                    state_d  = ALIGN;
                    shift_d  = data_in;
                    parity_d = OddParity ? ~^data_in : ^data_in;
                end
            end
            // Waits for a tick strictly after acceptance so the start bit
            // always spans a full tick interval.
            ALIGN: begin
                if (tick) begin
                    state_d = START;
                end
            end
            START: begin
                tx_d = ~UART_IDLE_LEVEL;
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LastBit) begin
                        state_d = HasParity ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = parity_q;
                if (tick) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == LastStop) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; tx follows the state one cycle later,
    // ready_out/busy track the state register itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            stop_q    <= 1'b0;
            parity_q  <= 1'b0;
            tx        <= UART_IDLE_LEVEL;
            ready_out <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            stop_q    <= stop_d;
            parity_q  <= parity_d;
            tx        <= tx_d;
            ready_out <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity / 1 stop,
// even parity / 1 stop, odd parity / 2 stops) share a tick every 4 clk.
// Expected line waveforms are derived from the frame format and the
// tick schedule, then compared cycle by cycle.
module tb_uart_tx;

    localparam int PM [3] = '{0, 1, 2};
    localparam int SB [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] data_in [3];
    logic [2:0] valid;
    logic [2:0] tx_w;
    logic [2:0] ready_w;
    logic [2:0] busy_w;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tick = ((cyc % 4) == 3);

    uart_tx #(.DataBits(8), .ParityMode(0), .StopBits(1)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in[0]), .valid_in(valid[0]),
        .ready_out(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.DataBits(8), .ParityMode(1), .StopBits(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in[1]), .valid_in(valid[1]),
        .ready_out(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.DataBits(8), .ParityMode(2), .StopBits(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in[2]), .valid_in(valid[2]),
        .ready_out(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         phase;
        logic [15:0] frame;
        int         len;
    } vec_t;

    vec_t tbl [8];

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: tx/ready/busy got %b want %b", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] outs(input int idx);
        return {tx_w[idx], ready_w[idx], busy_w[idx]};
    endfunction

    // Reference frame: index 0 is the start bit, then data LSB first,
    // optional parity, then stop bits.
    function automatic logic [15:0] build_frame(input logic [7:0] d, input int pm,
                                                input int sb, output int len);
        logic [15:0] f;
        int n;
        f = '0;
        n = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f[n] = d[i];
            n++;
        end
        if (pm != 0) begin
            f[n] = (pm == 1) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0);
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            f[n] = 1'b1;
            n++;
        end
        len = n;
        return f;
    endfunction

    // Offers data to one instance (optionally only when cyc%4==phase) and
    // returns the acceptance cycle, leaving the caller in the next cycle.
    task automatic send(input int idx, input logic [7:0] d, input int phase,
                        input bit hold, output int a);
        int waited;
        waited = 0;
        a = -1;
        @(posedge clk); #1;
        if (phase < 4) begin
            while ((cyc % 4) != phase) begin
                @(posedge clk); #1;
            end
        end
        data_in[idx] = d;
        valid[idx]   = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_w[idx]) begin
                a = cyc;
                break;
            end
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout dut%0d: ready got 0 want 1 within 200 cycles", idx);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!hold || a < 0) valid[idx] = 1'b0;
    endtask

    // Compares tx/ready/busy every cycle from acceptance+1 until ready
    // returns. Start bit begins 2 cycles after the first tick that follows
    // acceptance; each interval lasts 4 clk.
    task automatic check_frame(input string name, input int idx, input logic [15:0] f,
                               input int len, input int a);
        int t, first, last, k;
        logic etx, erdy;
        if (a < 0) return;
        t = a + 1;
        while ((t % 4) != 3) t++;
        first = t + 2;
        last  = first + 4 * len - 1;
        forever begin
            @(negedge clk);
            k = cyc;
            etx  = (k < first) ? 1'b1 : f[(k - first) / 4];
            erdy = (k >= last);
            chk3(name, outs(idx), {etx, erdy, ~erdy});
            if (k >= last) break;
        end
    endtask

    task automatic idle_check(input string name, input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk3(name, outs(idx), 3'b110);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, len, first, target, t;
        logic [15:0] f;

        tbl[0] = '{idx: 0, data: 8'hA5, phase: 4, frame: 16'h034A, len: 10};
        tbl[1] = '{idx: 1, data: 8'hA5, phase: 4, frame: 16'h054A, len: 11};
        tbl[2] = '{idx: 2, data: 8'hA5, phase: 4, frame: 16'h0F4A, len: 12};
        tbl[3] = '{idx: 0, data: 8'h00, phase: 4, frame: 16'h0200, len: 10};
        tbl[4] = '{idx: 1, data: 8'hFF, phase: 4, frame: 16'h05FE, len: 11};
        tbl[5] = '{idx: 2, data: 8'h00, phase: 4, frame: 16'h0E00, len: 12};
        tbl[6] = '{idx: 2, data: 8'h80, phase: 3, frame: 16'h0D00, len: 12};
        tbl[7] = '{idx: 0, data: 8'h3C, phase: 3, frame: 16'h0278, len: 10};

        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < 3; i++) data_in[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then idle with ticks running.
        for (int i = 0; i < 3; i++) chk3($sformatf("reset dut%0d", i), outs(i), 3'b110);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk3($sformatf("idle dut%0d", i), outs(i), 3'b110);
        end

        // Directed vectors, including tick coincident with acceptance.
        for (int v = 0; v < 8; v++) begin
            send(tbl[v].idx, tbl[v].data, tbl[v].phase, 1'b0, a);
            check_frame($sformatf("vec%0d dut%0d", v, tbl[v].idx), tbl[v].idx,
                        tbl[v].frame, tbl[v].len, a);
        end

        // Back-to-back with valid held; data changed while busy.
        send(0, 8'h3C, 4, 1'b1, a);
        data_in[0] = 8'hC3;
        f = build_frame(8'h3C, 0, 1, len);
        check_frame("b2b_first", 0, f, len, a);
        a2 = cyc;
        @(posedge clk); #1;
        data_in[0] = 8'h5A;
        valid[0]   = 1'b0;
        f = build_frame(8'hC3, 0, 1, len);
        check_frame("b2b_second", 0, f, len, a2);
        idle_check("b2b_no_third", 0, 20);

        // Reset during data bit 3 (payload 0x00 keeps the line low there).
        send(0, 8'h00, 4, 1'b0, a);
        t = a + 1;
        while ((t % 4) != 3) t++;
        first  = t + 2;
        target = first + 16 + 1;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk3("pre_reset_bit3", outs(0), 3'b001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk3("mid_frame_reset", outs(0), 3'b110);
        send(0, 8'h55, 4, 1'b0, a);
        f = build_frame(8'h55, 0, 1, len);
        check_frame("post_reset_55", 0, f, len, a);

        // Randomised frames against the reference model.
        for (int r = 0; r < 30; r++) begin
            int idx, ph;
            logic [7:0] d;
            idx = int'($urandom_range(0, 2));
            ph  = int'($urandom_range(0, 4));
            d   = 8'($urandom);
            send(idx, d, ph, 1'b0, a);
            f = build_frame(d, PM[idx], SB[idx], len);
            check_frame($sformatf("rand%0d dut%0d d=%02h", r, idx, d), idx, f, len, a);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
